// File: rtl/char_gen_pkg.sv
// Shared types and helpers for the character-generator fetch path:
// glyph/row/code widths, the fetch FSM state encoding and the ROM
// address packing used to index the character ROM.
package char_gen_pkg;

  localparam int GLYPH_W = 8;
  localparam int ROW_W   = 4;
  localparam int CODE_W  = 7;
  // Native ROM address: bank bit, glyph row, character code.
  localparam int BASE_AW = 1 + ROW_W + CODE_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2
  } fetch_state_t;

  // Build the native 12-bit ROM address {bank, row, code}.
  function automatic logic [BASE_AW-1:0] pack_addr(
    input logic              bank,
    input logic [ROW_W-1:0]  row,
    input logic [CODE_W-1:0] code
  );
    return {bank, row, code};
  endfunction

endpackage

// File: rtl/glyph_shifter.sv
// Glyph serializer: a one-byte hold register filled by the fetch FSM,
// a shift register that emits one pixel per pixel-clock enable, and a
// sticky underrun flag raised when a pixel slot finds nothing to send.
module glyph_shifter
  import char_gen_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit INVERT    = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_flush,
  input  logic               i_pix_ce,
  input  logic               i_cap,
  input  logic [GLYPH_W-1:0] i_cap_data,
  output logic               o_hold_full,
  output logic               o_pix_out,
  output logic               o_pix_valid,
  output logic               o_underrun
);

  localparam int CNT_W = $clog2(GLYPH_W);

  logic [GLYPH_W-1:0] r_hold;
  logic               r_hold_full;
  logic [GLYPH_W-1:0] r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_pix_out;
  logic               r_pix_valid;
  logic               r_underrun;

  logic               w_busy;
  logic               w_load;
  logic               w_starve;

  // Bit sent in the load slot, taken straight from the hold byte.
  function automatic logic first_bit(input logic [GLYPH_W-1:0] b);
    return MSB_FIRST ? b[GLYPH_W-1] : b[0];
  endfunction

  // Bit sent on the next shift: the shift register still holds the
  // already-sent bit at its output end, so look one position in.
  function automatic logic next_bit(input logic [GLYPH_W-1:0] b);
    return MSB_FIRST ? b[GLYPH_W-2] : b[1];
  endfunction

  function automatic logic [GLYPH_W-1:0] advance(input logic [GLYPH_W-1:0] b);
    return MSB_FIRST ? {b[GLYPH_W-2:0], 1'b0} : {1'b0, b[GLYPH_W-1:1]};
  endfunction

  assign w_busy   = (r_bit_cnt != '0);
  assign w_load   = i_pix_ce && !w_busy && r_hold_full;
  assign w_starve = i_pix_ce && !w_busy && !r_hold_full;

  // Hold register: filled by a ROM capture, emptied by a shifter load or a line flush.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (i_flush) begin
      r_hold_full <= 1'b0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else if (i_cap) begin
      r_hold      <= i_cap_data;
      r_hold_full <= 1'b1;
    end
  end

  // Serializer: one pixel per enabled slot; outputs hold while the enable is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_pix_out   <= 1'b0;
      r_pix_valid <= 1'b0;
    end else if (i_flush) begin
      r_bit_cnt   <= '0;
      r_pix_out   <= 1'b0;
      r_pix_valid <= 1'b0;
    end else if (i_pix_ce) begin
      if (w_busy) begin
        r_pix_out   <= next_bit(r_shift) ^ INVERT;
        r_shift     <= advance(r_shift);
        r_bit_cnt   <= r_bit_cnt - CNT_W'(1);
        r_pix_valid <= 1'b1;
      end else if (r_hold_full) begin
        r_shift     <= r_hold;
        r_bit_cnt   <= CNT_W'(GLYPH_W - 1);
        r_pix_out   <= first_bit(r_hold) ^ INVERT;
        r_pix_valid <= 1'b1;
      end else begin
        r_pix_out   <= 1'b0;
        r_pix_valid <= 1'b0;
      end
    end
  end

  // Sticky underrun: only reset clears it, a line flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_underrun <= 1'b0;
    end else if (!i_flush && w_starve) begin
      r_underrun <= 1'b1;
    end
  end

  assign o_hold_full = r_hold_full;
  assign o_pix_out   = r_pix_out;
  assign o_pix_valid = r_pix_valid;
  assign o_underrun  = r_underrun;

endmodule

// File: rtl/char_gen_fetch.sv
// Character-generator fetch/serializer. Accepts {code, row} from the
// text-line buffer, issues a single-cycle read to the character ROM,
// captures the registered ROM byte two cycles later and hands it to the
// glyph shifter. At most one fetch is in flight; a new character is only
// accepted when the hold byte is empty, which also guarantees a capture
// never collides with a shifter load.
module char_gen_fetch
  import char_gen_pkg::*;
#(
  parameter int ROM_AW    = 12,
  parameter bit FONT_BANK = 1'b0,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit INVERT    = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_ce,
  input  logic               line_start,
  input  logic               char_valid,
  input  logic [CODE_W-1:0]  char_code,
  input  logic [ROW_W-1:0]   char_row,
  output logic               char_ready,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic               rom_rd,
  input  logic [GLYPH_W-1:0] rom_data,
  output logic               pix_out,
  output logic               pix_valid,
  output logic               underrun
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_rom_rd;

  logic              w_ready_idle;
  logic              w_accept;
  logic              w_cap;
  logic              w_hold_full;

  // Fetch FSM next state: accept in IDLE, wait out the ROM latency, capture; a line flush returns to IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_ready_idle = 1'b0;
    w_accept     = 1'b0;
    w_cap        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready_idle = !w_hold_full && !line_start;
        if (char_valid && w_ready_idle) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        w_state_nxt = S_CAP;
      end
      S_CAP: begin
        w_cap       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (line_start) begin
      w_state_nxt = S_IDLE;
      w_cap       = 1'b0;
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ROM request: address latched on accept and held between fetches; rd pulses for one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rom_addr <= '0;
      r_rom_rd   <= 1'b0;
    end else begin
      r_rom_rd <= w_accept;
      if (w_accept) begin
        r_rom_addr <= ROM_AW'(pack_addr(FONT_BANK, char_row, char_code));
      end
    end
  end

  assign char_ready = w_ready_idle && reset_n;
  assign rom_addr   = r_rom_addr;
  assign rom_rd     = r_rom_rd;

  glyph_shifter #(
    .MSB_FIRST (MSB_FIRST),
    .INVERT    (INVERT)
  ) u_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (line_start),
    .i_pix_ce    (pix_ce),
    .i_cap       (w_cap),
    .i_cap_data  (rom_data),
    .o_hold_full (w_hold_full),
    .o_pix_out   (pix_out),
    .o_pix_valid (pix_valid),
    .o_underrun  (underrun)
  );

endmodule

// File: tb/tb_char_gen_fetch.sv
// Directed bench for char_gen_fetch. Two instances share the stimulus:
// the default build and one with FONT_BANK=1, MSB_FIRST=1, INVERT=1.
// Each instance reads a registered ROM model (1-cycle latency) filled
// with a known font pattern plus hand-placed glyph bytes.
module tb_char_gen_fetch;

  logic        clk;
  logic        reset_n;
  logic        pix_ce;
  logic        line_start;
  logic        char_valid;
  logic [6:0]  char_code;
  logic [3:0]  char_row;

  logic        char_ready,  char_ready2;
  logic [11:0] rom_addr,    rom_addr2;
  logic        rom_rd,      rom_rd2;
  logic [7:0]  rom_q,       rom_q2;
  logic        pix_out,     pix_out2;
  logic        pix_valid,   pix_valid2;
  logic        underrun,    underrun2;

  logic [7:0]  rom_mem [0:4095];

  // Every enabled pixel slot as {pix_valid, pix_out}, one queue per instance.
  logic [1:0]  slots [$];
  logic [1:0]  slots2 [$];

  int n_checks;
  int n_errors;

  char_gen_fetch #(
    .ROM_AW(12), .FONT_BANK(1'b0), .MSB_FIRST(1'b0), .INVERT(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .line_start(line_start),
    .char_valid(char_valid), .char_code(char_code), .char_row(char_row),
    .char_ready(char_ready), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .rom_data(rom_q), .pix_out(pix_out), .pix_valid(pix_valid), .underrun(underrun)
  );

  char_gen_fetch #(
    .ROM_AW(12), .FONT_BANK(1'b1), .MSB_FIRST(1'b1), .INVERT(1'b1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .line_start(line_start),
    .char_valid(char_valid), .char_code(char_code), .char_row(char_row),
    .char_ready(char_ready2), .rom_addr(rom_addr2), .rom_rd(rom_rd2),
    .rom_data(rom_q2), .pix_out(pix_out2), .pix_valid(pix_valid2), .underrun(underrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Character ROM models: registered data_out, updated only on rd.
  always @(posedge clk) if (rom_rd)  rom_q  <= rom_mem[rom_addr];
  always @(posedge clk) if (rom_rd2) rom_q2 <= rom_mem[rom_addr2];

  // Pixel collector: after each enabled edge, record what that slot produced.
  always @(posedge clk) begin
    #1;
    if (pix_ce && reset_n) begin
      slots.push_back({pix_valid, pix_out});
      slots2.push_back({pix_valid2, pix_out2});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nvalid(input int sel);
    int n = 0;
    if (sel == 1) begin
      for (int i = 0; i < slots.size(); i++) if (slots[i][1]) n++;
    end else begin
      for (int i = 0; i < slots2.size(); i++) if (slots2[i][1]) n++;
    end
    return n;
  endfunction

  // idx-th valid pixel (in arrival order) of the chosen instance.
  function automatic logic vbit(input int sel, input int idx);
    int n = 0;
    if (sel == 1) begin
      for (int i = 0; i < slots.size(); i++) begin
        if (slots[i][1]) begin
          if (n == idx) return slots[i][0];
          n++;
        end
      end
    end else begin
      for (int i = 0; i < slots2.size(); i++) begin
        if (slots2[i][1]) begin
          if (n == idx) return slots2[i][0];
          n++;
        end
      end
    end
    return 1'bx;
  endfunction

  // Byte j of the valid pixel stream, first pixel placed at bit 0.
  function automatic logic [7:0] vbyte(input int sel, input int j);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = vbit(sel, j * 8 + b);
    return r;
  endfunction

  task automatic wait_valid(input int sel, input int n, input int budget, input string tag);
    int t = 0;
    while (nvalid(sel) < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(nvalid(sel) >= n), 32'd1);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    char_valid = 1'b0;
    pix_ce     = 1'b0;
    line_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("reset_clears_underrun", 32'(underrun), 32'd0);
  endtask

  // Four characters (codes 0x10..0x13, row 5) with char_valid held high.
  task automatic run_stream(input bit slow);
    logic [6:0] codes [4];
    logic [7:0] exp_b [4];
    int         acc [4];
    int         exp_acc [4];
    int         k;
    int         acc_prev;
    int         bad;
    bit         done;
    codes = '{7'h10, 7'h11, 7'h12, 7'h13};
    exp_b = '{8'h3C, 8'hE1, 8'h96, 8'h7B};
    acc   = '{-1, -1, -1, -1};
    if (slow) exp_acc = '{0, 9, 41, 73};
    else      exp_acc = '{0, 5, 13, 21};
    do_reset();
    slots.delete();
    slots2.delete();
    k = 0;
    acc_prev = 0;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(negedge clk);
      if (acc_prev != 0) begin
        acc[k] = c - 1;
        k++;
      end
      if (slots.size() >= 32) begin
        done = 1'b1;
        break;
      end
      pix_ce     = slow ? ((c >= 8) && (c % 4 == 0)) : (c >= 4);
      char_valid = (k < 4);
      char_code  = codes[(k < 4) ? k : 3];
      char_row   = 4'd5;
      #1;
      acc_prev = (char_valid && char_ready) ? 1 : 0;
      if (slow && c == 5)  chk("slow_ready_low_hold_full", 32'(char_ready), 32'd0);
      if (slow && c == 9)  chk("slow_ready_after_load", 32'(char_ready), 32'd1);
      if (slow && c == 20) chk("slow_ready_low_while_shifting", 32'(char_ready), 32'd0);
    end
    pix_ce     = 1'b0;
    char_valid = 1'b0;
    chk(slow ? "slow_done" : "fast_done", 32'(done), 32'd1);
    chk(slow ? "slow_underrun" : "fast_underrun", 32'(underrun), 32'd0);
    chk(slow ? "slow_accepts" : "fast_accepts", 32'(k), 32'd4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("%s_acc_cycle%0d", slow ? "slow" : "fast", j), 32'(acc[j]), 32'(exp_acc[j]));
    bad = 0;
    for (int i = 0; i < 32 && i < slots.size(); i++) if (!slots[i][1]) bad++;
    chk(slow ? "slow_contiguous" : "fast_contiguous", 32'(bad), 32'd0);
    for (int j = 0; j < 4; j++)
      chk($sformatf("%s_byte%0d", slow ? "slow" : "fast", j), 32'(vbyte(1, j)), 32'(exp_b[j]));
  endtask

  initial begin
    logic [7:0] seq1;
    logic [7:0] seq2;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'(i) ^ 8'h5A;
    rom_mem[12'h1C1] = 8'hA5;
    rom_mem[12'h9C1] = 8'h81;
    rom_mem[12'h7FF] = 8'hFF;
    rom_mem[12'h290] = 8'h3C;
    rom_mem[12'h291] = 8'hE1;
    rom_mem[12'h292] = 8'h96;
    rom_mem[12'h293] = 8'h7B;

    // Reset held for three cycles with live-looking inputs.
    reset_n    = 1'b0;
    pix_ce     = 1'b1;
    line_start = 1'b0;
    char_valid = 1'b1;
    char_code  = 7'h41;
    char_row   = 4'd3;
    repeat (3) begin
      @(negedge clk);
      chk("rst_char_ready", 32'(char_ready), 32'd0);
      chk("rst_rom_rd", 32'(rom_rd), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_pix_out", 32'(pix_out), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_rom_rd_p", 32'(rom_rd2), 32'd0);
    end

    // Single fetch: code 0x41 row 3 (byte A5 in bank 0, 81 in bank 1).
    slots.delete();
    slots2.delete();
    reset_n = 1'b1;
    #1;
    chk("single_ready", 32'(char_ready), 32'd1);
    @(negedge clk);
    char_valid = 1'b0;
    chk("single_rom_rd", 32'(rom_rd), 32'd1);
    chk("single_rom_addr", 32'(rom_addr), 32'h1C1);
    chk("single_ready_busy", 32'(char_ready), 32'd0);
    chk("param_rom_rd", 32'(rom_rd2), 32'd1);
    chk("param_rom_addr", 32'(rom_addr2), 32'h9C1);
    @(negedge clk);
    chk("single_rom_rd_pulse", 32'(rom_rd), 32'd0);
    chk("single_rom_addr_held", 32'(rom_addr), 32'h1C1);
    wait_valid(1, 8, 40, "single_pixels_arrive");
    wait_valid(2, 8, 40, "param_pixels_arrive");
    seq1 = 8'hA5;
    seq2 = 8'h7E;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("single_pix%0d", i), 32'(vbit(1, i)), 32'(seq1[i]));
      chk($sformatf("param_pix%0d", i), 32'(vbit(2, i)), 32'(seq2[i]));
    end

    // Streaming with pixel enable every cycle, then every 4th cycle.
    run_stream(1'b0);
    run_stream(1'b1);

    // Underrun: enable with nothing queued; flag must survive a line flush.
    pix_ce = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("underrun_pix_valid", 32'(pix_valid), 32'd0);
    chk("underrun_pix_out", 32'(pix_out), 32'd0);
    chk("underrun_set", 32'(underrun), 32'd1);
    chk("underrun_param_pix_out", 32'(pix_out2), 32'd0);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    @(negedge clk);
    chk("underrun_sticky_flush", 32'(underrun), 32'd1);
    pix_ce = 1'b0;

    // Flush during the read cycle of a fetch for byte FF.
    do_reset();
    pix_ce     = 1'b1;
    char_valid = 1'b1;
    char_code  = 7'h7F;
    char_row   = 4'd15;
    #1;
    chk("flush_ready", 32'(char_ready), 32'd1);
    @(negedge clk);
    char_valid = 1'b0;
    chk("flush_rom_rd", 32'(rom_rd), 32'd1);
    chk("flush_rom_addr", 32'(rom_addr), 32'h7FF);
    line_start = 1'b1;
    slots.delete();
    slots2.delete();
    @(negedge clk);
    line_start = 1'b0;
    #1;
    chk("flush_rom_rd_low", 32'(rom_rd), 32'd0);
    chk("flush_back_to_idle", 32'(char_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("flush_no_leak", 32'(nvalid(1)), 32'd0);
    chk("flush_pix_valid", 32'(pix_valid), 32'd0);
    char_valid = 1'b1;
    char_code  = 7'h41;
    char_row   = 4'd3;
    @(negedge clk);
    char_valid = 1'b0;
    wait_valid(1, 8, 40, "flush_next_arrives");
    for (int i = 0; i < 8; i++)
      chk($sformatf("flush_next_pix%0d", i), 32'(vbit(1, i)), 32'(seq1[i]));
    pix_ce = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
